// File: rtl/adc_spi_responder.sv
// MCP3202-style SPI responder: oversamples the master's SCLK/CS/MOSI on clk and shifts back a port-supplied sample.
// Define ADC_RESP_LSBF_EN to enable the LSB-first tail repeat when the command's MSBF bit is 0.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_clk,
  input  logic                 adc_cs,
  input  logic                 adc_mosi,
  output logic                 adc_miso,
  output logic                 miso_oe,
  input  logic [DATA_BITS-1:0] ch0_sample,
  input  logic [DATA_BITS-1:0] ch1_sample,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [2:0]           last_cmd
);

  // state        | meaning
  // WAIT_CS_HIGH | after reset, ignore the bus until CS is seen high
  // IDLE         | deselected, waiting for CS to fall
  // START        | skipping leading zeros, waiting for the start bit
  // CMD          | capturing SGL, ODD, MSBF
  // NUL          | next SCLK fall drives the null bit
  // DATA         | shifting the sample out MSB first
  // TAIL         | after D0: LSB-first repeat (optional) or zeros
  typedef enum logic [2:0] {
    WAIT_CS_HIGH, IDLE, START, CMD, NUL, DATA, TAIL
  } state_t;

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] TAIL_END = CW'(DATA_BITS);
  localparam logic [CW-1:0] CMD_LAST = CW'(2);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, cs_d;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, abort;

  logic [DATA_BITS-1:0] shreg, sel_value;
  logic [DATA_BITS:0]   diff_0m1, diff_1m0;
  logic [CW-1:0]        cnt;
  logic                 sgl, odd, d0_sent, tail_bit;

  logic miso_nxt, oe_nxt, done_nxt, error_nxt;

  // CS sync flops reset low so a frame already in progress at reset is not taken as idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], adc_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign abort     = cs_rise && (state != WAIT_CS_HIGH);

  always_comb begin
    diff_0m1 = {1'b0, ch0_sample} - {1'b0, ch1_sample};
    diff_1m0 = {1'b0, ch1_sample} - {1'b0, ch0_sample};
    sel_value = ch0_sample;
    if (sgl)
      sel_value = odd ? ch1_sample : ch0_sample;
    else if (odd)
      sel_value = diff_1m0[DATA_BITS] ? '0 : diff_1m0[DATA_BITS-1:0];
    else
      sel_value = diff_0m1[DATA_BITS] ? '0 : diff_0m1[DATA_BITS-1:0];
  end

`ifdef ADC_RESP_LSBF_EN
  assign tail_bit = (!last_cmd[0] && (cnt < TAIL_END)) ? shreg[cnt] : 1'b0;
`else
  assign tail_bit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_CS_HIGH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        WAIT_CS_HIGH: if (cs_s) state_nxt = IDLE;
        IDLE:         if (cs_fall) state_nxt = START;
        START:        if (sclk_rise && mosi_s) state_nxt = CMD;
        CMD:          if (sclk_rise && cnt == CMD_LAST) state_nxt = NUL;
        NUL:          if (sclk_fall) state_nxt = DATA;
        DATA:         if (sclk_rise && d0_sent) state_nxt = TAIL;
        TAIL:         state_nxt = TAIL;
        default:      state_nxt = WAIT_CS_HIGH;
      endcase
    end
  end

  always_comb begin
    miso_nxt  = adc_miso;
    oe_nxt    = miso_oe;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    if (abort) begin
      miso_nxt  = 1'b1;
      oe_nxt    = 1'b0;
      error_nxt = (state == CMD) || (state == NUL) || (state == DATA);
    end else begin
      case (state)
        NUL: if (sclk_fall) begin
          oe_nxt   = 1'b1;
          miso_nxt = 1'b0;
        end
        DATA: begin
          if (sclk_fall && !d0_sent) miso_nxt = shreg[cnt];
          if (sclk_rise && d0_sent)  done_nxt = 1'b1;
        end
        TAIL: if (sclk_fall) miso_nxt = tail_bit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_miso    <= 1'b1;
      miso_oe     <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      adc_miso    <= miso_nxt;
      miso_oe     <= oe_nxt;
      frame_done  <= done_nxt;
      frame_error <= error_nxt;
    end
  end

  // cnt indexes command bits in CMD, counts down D11..D0 in DATA, and up D1..D11 in TAIL
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shreg    <= '0;
      sgl      <= 1'b0;
      odd      <= 1'b0;
      d0_sent  <= 1'b0;
      last_cmd <= 3'b000;
    end else if (!abort) begin
      case (state)
        START: if (sclk_rise && mosi_s) begin
          cnt     <= '0;
          d0_sent <= 1'b0;
        end
        CMD: if (sclk_rise) begin
          cnt <= cnt + 1'b1;
          if (cnt == '0) sgl <= mosi_s;
          else if (cnt == CW'(1)) odd <= mosi_s;
          else begin
            shreg    <= sel_value;
            last_cmd <= {sgl, odd, mosi_s};
          end
        end
        NUL: if (sclk_fall) cnt <= LAST_IDX;
        DATA: begin
          if (sclk_fall && !d0_sent) begin
            if (cnt == '0) d0_sent <= 1'b1;
            else           cnt <= cnt - 1'b1;
          end
          if (sclk_rise && d0_sent) cnt <= CW'(1);
        end
        TAIL: if (sclk_fall && cnt != TAIL_END) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboarded bench for adc_spi_responder: a bus master pushes expected MISO bits and frame events,
// independent monitors pop and compare them against what the responder produces.
module tb_adc_spi_responder;
  localparam int SYNC_STAGES = 2;
  localparam int DATA_BITS   = 12;
`ifdef ADC_RESP_LSBF_EN
  localparam bit LSBF = 1'b1;
`else
  localparam bit LSBF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_clk, adc_cs, adc_mosi;
  logic        adc_miso, miso_oe;
  logic [11:0] ch0, ch1;
  logic        frame_done, frame_error;
  logic [2:0]  last_cmd;

  adc_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .reset(reset), .adc_clk(adc_clk), .adc_cs(adc_cs), .adc_mosi(adc_mosi),
    .adc_miso(adc_miso), .miso_oe(miso_oe), .ch0_sample(ch0), .ch1_sample(ch1),
    .frame_done(frame_done), .frame_error(frame_error), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [2:0] cmd;
  } ev_t;

  bit  bit_q[$];
  ev_t ev_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] ref_value(input bit sgl, input bit odd, input int a, input int b);
    int d;
    if (sgl) return odd ? 12'(b) : 12'(a);
    d = odd ? b - a : a - b;
    if (d < 0) d = 0;
    return 12'(d);
  endfunction

  // MISO monitor: the master samples on its rising edge
  always @(posedge adc_clk) begin
    if (!adc_cs && miso_oe) begin
      if (bit_q.size() == 0) fail_now("unexpected_miso_bit");
      else check("miso_bit", 32'(adc_miso), 32'(bit_q.pop_front()));
    end
  end

  // frame event monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done && frame_error) fail_now("done_and_error_together");
      if (frame_done || frame_error) begin
        if (ev_q.size() == 0) begin
          fail_now(frame_done ? "unexpected_frame_done" : "unexpected_frame_error");
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          check("event_is_done", 32'(frame_done), 32'(e.is_done));
          if (frame_done) check("last_cmd", 32'(last_cmd), 32'(e.cmd));
        end
      end
    end
  end

  // after any CS rise the line must return to idle within SYNC_STAGES+2 cycles
  always @(posedge adc_cs) begin
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
    check("idle_oe", 32'(miso_oe), 32'd0);
    check("idle_miso", 32'(adc_miso), 32'd1);
  end

  task automatic frame(input int lead, input bit sgl, input bit odd, input bit msbf,
                       input int nrises, input int half, input int reset_at);
    logic [11:0] v;
    bit          exp_bits[$];
    bit          rst_done;
    bit          b;
    ev_t         e;
    v = ref_value(sgl, odd, int'(ch0), int'(ch1));
    exp_bits.push_back(1'b0);
    for (int i = 11; i >= 0; i--) exp_bits.push_back(v[i]);
    for (int t = 0; t < 48; t++) exp_bits.push_back((LSBF && !msbf && t < 11) ? v[t+1] : 1'b0);
    e.cmd = {sgl, odd, msbf};
    if (reset_at < 0) begin
      if (nrises >= lead + 17) begin e.is_done = 1'b1; ev_q.push_back(e); end
      else if (nrises >= lead + 1) begin e.is_done = 1'b0; ev_q.push_back(e); end
    end
    rst_done = 1'b0;
    adc_cs = 1'b0;
    wait_clk(half);
    for (int k = 0; k < nrises; k++) begin
      if (k < lead) b = 1'b0;
      else if (k == lead) b = 1'b1;
      else if (k == lead + 1) b = sgl;
      else if (k == lead + 2) b = odd;
      else if (k == lead + 3) b = msbf;
      else b = 1'($urandom);
      adc_mosi = b;
      wait_clk(half);
      if (k == reset_at) begin
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        rst_done = 1'b1;
        check("rst_mid_miso", 32'(adc_miso), 32'd1);
        check("rst_mid_oe", 32'(miso_oe), 32'd0);
        check("rst_mid_last_cmd", 32'(last_cmd), 32'd0);
      end
      if (!rst_done && k >= lead + 4) bit_q.push_back(exp_bits[k - lead - 4]);
      adc_clk = 1'b1;
      if (k == lead + 4) begin
        ch0 = 12'($urandom);
        ch1 = 12'($urandom);
      end
      wait_clk(half);
      adc_clk = 1'b0;
    end
    wait_clk(half);
    adc_cs = 1'b1;
    wait_clk(12);
  endtask

  initial begin
    int lead, n, half;
    bit s, o, m;
    reset = 1'b1;
    adc_clk = 1'b0;
    adc_cs = 1'b1;
    adc_mosi = 1'b0;
    ch0 = '0;
    ch1 = '0;
    wait_clk(5);
    check("reset_miso", 32'(adc_miso), 32'd1);
    check("reset_oe", 32'(miso_oe), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_error", 32'(frame_error), 32'd0);
    check("reset_last_cmd", 32'(last_cmd), 32'd0);
    reset = 1'b0;
    wait_clk(10);

    ch0 = 12'hA5C; ch1 = 12'h123;
    frame(0, 1'b1, 1'b0, 1'b1, 20, 8, -1);
    ch0 = 12'h555; ch1 = 12'h001;
    frame(3, 1'b1, 1'b1, 1'b1, 22, 6, -1);
    ch0 = 12'h100; ch1 = 12'h300;
    frame(0, 1'b0, 1'b0, 1'b1, 18, 5, -1);
    ch0 = 12'h300; ch1 = 12'h100;
    frame(1, 1'b0, 1'b0, 1'b0, 19, 7, -1);
    ch0 = 12'h100; ch1 = 12'h300;
    frame(0, 1'b0, 1'b1, 1'b1, 18, 5, -1);
    ch0 = 12'hFFF; ch1 = 12'h000;
    frame(0, 1'b0, 1'b1, 1'b0, 18, 5, -1);
    ch0 = 12'h6C3; ch1 = 12'h2B7;
    frame(0, 1'b1, 1'b0, 1'b1, 10, 6, -1);
    frame(2, 1'b1, 1'b1, 1'b1, 22, 6, -1);
    ch0 = 12'h9E1; ch1 = 12'h044;
    frame(1, 1'b1, 1'b0, 1'b1, 25, 6, 10);
    frame(0, 1'b1, 1'b0, 1'b1, 20, 6, -1);
    ch0 = 12'h801; ch1 = 12'h7FE;
    frame(0, 1'b1, 1'b0, 1'b0, 32, 5, -1);

    for (int i = 0; i < 24; i++) begin
      lead = $urandom_range(0, 3);
      s = 1'($urandom);
      o = 1'($urandom);
      m = 1'($urandom);
      half = $urandom_range(5, 9);
      ch0 = 12'($urandom);
      ch1 = 12'($urandom);
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, lead + 16);
      else n = lead + 17 + $urandom_range(0, 14);
      frame(lead, s, o, m, n, half, -1);
    end

    wait_clk(20);
    check("bit_queue_drained", 32'(bit_q.size()), 32'd0);
    check("event_queue_drained", 32'(ev_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
